// File: rtl/i2cmb_cmd_queue_if.sv
// Handshake bundle between the I2CMB register front end, the command queue and the byte FSM.
// The slave modport is the queue's view; master is the view of whatever drives it.
interface i2cmb_cmd_queue_if #(
    parameter int DEPTH     = 8,
    parameter int DATA_W    = 8,
    parameter int NUM_BUSES = 16
);
    localparam int BUS_W = (NUM_BUSES > 1) ? $clog2(NUM_BUSES) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              push_i;
    logic [2:0]        push_cmd_i;
    logic [DATA_W-1:0] push_data_i;
    logic              full_o;
    logic              afull_o;
    logic [CNT_W-1:0]  count_o;
    logic              cmd_valid_o;
    logic              cmd_ready_i;
    logic [2:0]        cmd_o;
    logic [DATA_W-1:0] data_o;
    logic [BUS_W-1:0]  bus_o;
    logic              rsp_valid_i;
    logic              rsp_err_i;
    logic              busy_o;
    logic              err_o;
    logic              overflow_o;
    logic              err_clr_i;

    modport master (
        output push_i, push_cmd_i, push_data_i, cmd_ready_i, rsp_valid_i, rsp_err_i, err_clr_i,
        input  full_o, afull_o, count_o, cmd_valid_o, cmd_o, data_o, bus_o, busy_o, err_o,
               overflow_o
    );

    modport slave (
        input  push_i, push_cmd_i, push_data_i, cmd_ready_i, rsp_valid_i, rsp_err_i, err_clr_i,
        output full_o, afull_o, count_o, cmd_valid_o, cmd_o, data_o, bus_o, busy_o, err_o,
               overflow_o
    );
endinterface

// File: rtl/i2cmb_cmd_queue.sv
// Bus-tagged command FIFO feeding the I2CMB byte FSM, one command outstanding at a time.
//   state       | meaning
//   ST_IDLE     | nothing offered; waits for a stored entry and no sticky error
//   ST_ISSUE    | head command offered on cmd_valid_o until the FSM takes it
//   ST_WAIT_RSP | command popped; waits for the FSM response (error flushes queue)
module i2cmb_cmd_queue #(
    parameter int DEPTH     = 8,
    parameter int DATA_W    = 8,
    parameter int NUM_BUSES = 16,
    parameter int AFULL_LVL = DEPTH - 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    i2cmb_cmd_queue_if.slave q_if
);
    localparam int BUS_W = (NUM_BUSES > 1) ? $clog2(NUM_BUSES) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] CMD_SET_BUS  = 3'b110;
    localparam logic [2:0] CMD_RESERVED = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RSP
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [BUS_W-1:0]  tag_q, tag_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;
    logic              valid_q, valid_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [BUS_W-1:0]  bus_q, bus_d;

    logic [2:0]        mem_cmd_q  [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [BUS_W-1:0]  mem_bus_q  [DEPTH];

    logic wr_en, pop, flush, err_set, ovf_set, full;

    assign full = (count_q == CNT_W'(DEPTH));

    // Push decode, all against pre-edge flags and fill level.
    always_comb begin
        wr_en   = 1'b0;
        err_set = 1'b0;
        ovf_set = 1'b0;
        tag_d   = tag_q;
        if (q_if.push_i) begin
            if (err_q) begin
                ovf_set = 1'b1;
            end else if (q_if.push_cmd_i == CMD_RESERVED) begin
                err_set = 1'b1;
            end else if (q_if.push_cmd_i == CMD_SET_BUS) begin
                if (32'(q_if.push_data_i) < NUM_BUSES) begin
                    tag_d = q_if.push_data_i[BUS_W-1:0];
                end else begin
                    err_set = 1'b1;
                end
            end else if (full) begin
                ovf_set = 1'b1;
            end else begin
                wr_en = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        bus_d   = bus_q;
        pop     = 1'b0;
        flush   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0 && !err_q) begin
                    state_d = ST_ISSUE;
                    valid_d = 1'b1;
                    cmd_d   = mem_cmd_q[rd_ptr_q];
                    data_d  = mem_data_q[rd_ptr_q];
                    bus_d   = mem_bus_q[rd_ptr_q];
                end
            end
            ST_ISSUE: begin
                if (q_if.cmd_ready_i) begin
                    pop     = 1'b1;
                    valid_d = 1'b0;
                    state_d = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (q_if.rsp_valid_i) begin
                    state_d = ST_IDLE;
                    flush   = q_if.rsp_err_i;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // A push accepted in the flush cycle is written first and then discarded with the rest.
    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !wr_en) begin
            count_d = count_q - CNT_W'(1);
        end
        if (flush) begin
            rd_ptr_d = wr_ptr_d;
            count_d  = '0;
        end
        err_d = err_set | flush | (err_q & ~q_if.err_clr_i);
        ovf_d = ovf_set | (ovf_q & ~q_if.err_clr_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tag_q    <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            cmd_q    <= '0;
            data_q   <= '0;
            bus_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            tag_q    <= tag_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            cmd_q    <= cmd_d;
            data_q   <= data_d;
            bus_q    <= bus_d;
        end
    end

    // Storage needs no reset: entries are only read once count_q says they were written.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_cmd_q[wr_ptr_q]  <= q_if.push_cmd_i;
            mem_data_q[wr_ptr_q] <= q_if.push_data_i;
            mem_bus_q[wr_ptr_q]  <= tag_q;
        end
    end

    assign q_if.full_o      = full;
    assign q_if.afull_o     = (count_q >= CNT_W'(AFULL_LVL));
    assign q_if.count_o     = count_q;
    assign q_if.cmd_valid_o = valid_q;
    assign q_if.cmd_o       = cmd_q;
    assign q_if.data_o      = data_q;
    assign q_if.bus_o       = bus_q;
    assign q_if.busy_o      = (state_q != ST_IDLE) || (count_q != '0);
    assign q_if.err_o       = err_q;
    assign q_if.overflow_o  = ovf_q;
endmodule
